// File: rtl/mat_addsub_ctrl.sv
// mat_addsub_ctrl: sequencer for the matrix coprocessor's element-wise add/sub path.
// On an accepted start it reads ROWS rows of A and B from the bank. It applies a
// lane-wise signed add (op=1) or subtract (op=0) to each row pair, writes each
// result row back, and flags per-row and global overflow.
//
// Ports:
//   clk, rst (async, active-low)
//   start, op                 - command strobe and operation, from the decoder
//   busy, done                - command in flight / one-cycle completion pulse
//   rd_en, rd_addr            - bank row read; rd_data_a/rd_data_b return one cycle later
//   wr_en, wr_addr, wr_data   - result row write strobe
//   ovf, ovf_row              - sticky overflow flags of the current/last command
//
// Build option: define MAT_SATURATE_EN to clamp overflowing lanes to +max/-min
// instead of wrapping. Latency and handshake are the same in both builds.
module mat_addsub_ctrl #(
    parameter int unsigned ROWS   = 5,
    parameter int unsigned LANES  = 5,
    parameter int unsigned LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op,
    output logic                    busy,
    output logic                    rd_en,
    output logic [2:0]              rd_addr,
    input  logic [LANES*LANE_W-1:0] rd_data_a,
    input  logic [LANES*LANE_W-1:0] rd_data_b,
    output logic                    wr_en,
    output logic [2:0]              wr_addr,
    output logic [LANES*LANE_W-1:0] wr_data,
    output logic                    ovf,
    output logic [ROWS-1:0]         ovf_row,
    output logic                    done
);

    localparam int unsigned W      = LANES * LANE_W;
    localparam int unsigned ADDR_W = 3;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
`ifdef MAT_SATURATE_EN
    localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                done_q, done_d;
    logic                op_q, op_d;
    logic                clr_ovf_c;

    // Stage 1 tracks which row's data arrives on rd_data_* this cycle.
    logic                s1_vld_q;
    logic [ADDR_W-1:0]   s1_addr_q;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]        wr_data_q, wr_data_d;
    logic                ovf_q, ovf_d;
    logic [ROWS-1:0]     ovf_row_q, ovf_row_d;

    logic [LANE_W:0]     a_x, b_x, s_x;
    logic                lane_ovf;
    logic                row_ovf_c;
    logic [W-1:0]        res_c;

    // Control FSM: DONE is the final drain cycle. It leaves IDLE as the state
    // while the done pulse is visible, so a back-to-back start is taken there.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        done_d    = 1'b0;
        op_d      = op_q;
        clr_ovf_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    op_d      = op;
                    clr_ovf_c = 1'b1;
                end
            end
            S_RUN: begin
                if (rd_addr_q == LAST_ROW) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane-wise 9-bit signed add/sub; overflow when the two top bits differ.
    always_comb begin
        a_x       = '0;
        b_x       = '0;
        s_x       = '0;
        lane_ovf  = 1'b0;
        row_ovf_c = 1'b0;
        res_c     = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            a_x       = {rd_data_a[k*LANE_W+LANE_W-1], rd_data_a[k*LANE_W +: LANE_W]};
            b_x       = {rd_data_b[k*LANE_W+LANE_W-1], rd_data_b[k*LANE_W +: LANE_W]};
            s_x       = op_q ? (a_x + b_x) : (a_x - b_x);
            lane_ovf  = s_x[LANE_W] ^ s_x[LANE_W-1];
            row_ovf_c = row_ovf_c | lane_ovf;
`ifdef MAT_SATURATE_EN
            if (lane_ovf) begin
                res_c[k*LANE_W +: LANE_W] = s_x[LANE_W] ? SAT_MIN : SAT_MAX;
            end else begin
                res_c[k*LANE_W +: LANE_W] = s_x[LANE_W-1:0];
            end
`else
            res_c[k*LANE_W +: LANE_W] = s_x[LANE_W-1:0];
`endif
        end
    end

    // Stage 2: result row write and sticky overflow accumulation.
    always_comb begin
        wr_en_d   = s1_vld_q;
        wr_addr_d = s1_vld_q ? s1_addr_q : '0;
        wr_data_d = s1_vld_q ? res_c : '0;
        ovf_d     = ovf_q;
        ovf_row_d = ovf_row_q;
        if (clr_ovf_c) begin
            ovf_d     = 1'b0;
            ovf_row_d = '0;
        end else if (s1_vld_q && row_ovf_c) begin
            ovf_d                = 1'b1;
            ovf_row_d[s1_addr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
            op_q      <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
            ovf_row_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            done_q    <= done_d;
            op_q      <= op_d;
            s1_vld_q  <= rd_en_q;
            s1_addr_q <= rd_addr_q;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            ovf_row_q <= ovf_row_d;
        end
    end

    assign busy    = busy_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign ovf     = ovf_q;
    assign ovf_row = ovf_row_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mat_addsub_ctrl.sv
// Self-checking bench for mat_addsub_ctrl: directed test-plan commands, random
// commands against an integer reference model, start-while-busy and mid-command reset.
module tb_mat_addsub_ctrl;

    localparam int ROWS = 5;
    localparam int W    = 40;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op;
    logic          busy;
    logic          rd_en;
    logic [2:0]    rd_addr;
    logic [W-1:0]  rd_data_a;
    logic [W-1:0]  rd_data_b;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          ovf;
    logic [ROWS-1:0] ovf_row;
    logic          done;

    mat_addsub_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ovf       (ovf),
        .ovf_row   (ovf_row),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix bank: registered read, data valid the cycle after rd_en.
    logic [W-1:0] mem_a [8];
    logic [W-1:0] mem_b [8];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]    exp_data [ROWS];
    logic [ROWS-1:0] exp_row_all;
    logic [W-1:0]    got_data [ROWS];
    logic [ROWS-1:0] got_row;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] pack5(input int l4, input int l3, input int l2,
                                           input int l1, input int l0);
        return {8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    // Reference: integer arithmetic on signed lane values, then wrap or clamp.
    task automatic model(input bit opv);
        logic [7:0] la, lb;
        int x, y, s;
        for (int r = 0; r < ROWS; r++) begin
            exp_row_all[r] = 1'b0;
            exp_data[r]    = '0;
            for (int k = 0; k < 5; k++) begin
                la = mem_a[r][k*8 +: 8];
                lb = mem_b[r][k*8 +: 8];
                x  = int'($signed(la));
                y  = int'($signed(lb));
                s  = opv ? x + y : x - y;
                if (s > 127 || s < -128) exp_row_all[r] = 1'b1;
`ifdef MAT_SATURATE_EN
                if (s > 127) s = 127;
                else if (s < -128) s = -128;
`endif
                exp_data[r][k*8 +: 8] = 8'(s);
            end
        end
    endtask

    task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int r = 0; r < 8; r++) begin
            mem_a[r] = a;
            mem_b[r] = b;
        end
    endtask

    task automatic set_random();
        for (int r = 0; r < 8; r++) begin
            mem_a[r] = {8'($urandom), 32'($urandom)};
            mem_b[r] = {8'($urandom), 32'($urandom)};
        end
    endtask

    // Issue one command (called just after a negedge) and check every cycle
    // from the one after E0 to the one after E7.
    task automatic run_cmd(input bit opv, input bit inject);
        logic [ROWS-1:0] m;
        model(opv);
        start = 1'b1;
        op    = opv;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (inject && c == 2) begin
                start = 1'b1;
                op    = ~opv;
            end
            if (inject && c == 3) start = 1'b0;
            check($sformatf("busy c%0d", c), 64'(busy), 64'(c <= 6));
            check($sformatf("done c%0d", c), 64'(done), 64'(c == 7));
            check($sformatf("rd_en c%0d", c), 64'(rd_en), 64'(c <= 4));
            if (c <= 4) check($sformatf("rd_addr c%0d", c), 64'(rd_addr), 64'(c));
            check($sformatf("wr_en c%0d", c), 64'(wr_en), 64'(c >= 2 && c <= 6));
            if (c >= 2 && c <= 6) begin
                check($sformatf("wr_addr c%0d", c), 64'(wr_addr), 64'(c - 2));
                check($sformatf("wr_data row%0d", c - 2), 64'(wr_data), 64'(exp_data[c-2]));
                got_data[c-2] = wr_data;
            end
            for (int r = 0; r < ROWS; r++) m[r] = exp_row_all[r] && (r <= c - 2);
            check($sformatf("ovf_row c%0d", c), 64'(ovf_row), 64'(m));
            check($sformatf("ovf c%0d", c), 64'(ovf), 64'(|m));
        end
        got_row = ovf_row;
    endtask

    task automatic idle_check(input int n, input logic [ROWS-1:0] hold_row);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle busy", 64'(busy), 64'(0));
            check("idle done", 64'(done), 64'(0));
            check("idle wr_en", 64'(wr_en), 64'(0));
            check("idle ovf_row hold", 64'(ovf_row), 64'(hold_row));
            check("idle ovf hold", 64'(ovf), 64'(|hold_row));
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " busy"}, 64'(busy), 64'(0));
        check({pfx, " rd_en"}, 64'(rd_en), 64'(0));
        check({pfx, " rd_addr"}, 64'(rd_addr), 64'(0));
        check({pfx, " wr_en"}, 64'(wr_en), 64'(0));
        check({pfx, " wr_addr"}, 64'(wr_addr), 64'(0));
        check({pfx, " wr_data"}, 64'(wr_data), 64'(0));
        check({pfx, " ovf"}, 64'(ovf), 64'(0));
        check({pfx, " ovf_row"}, 64'(ovf_row), 64'(0));
        check({pfx, " done"}, 64'(done), 64'(0));
    endtask

    initial begin
        bit opv, inj;
        start = 1'b0;
        op    = 1'b0;
        set_all('0, '0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #20;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle_check(2, '0);

        // Sub, no overflow
        set_all(pack5(50, 40, 30, 20, 10), pack5(45, 35, 25, 15, 5));
        run_cmd(1'b0, 1'b0);
        check("t1 row0 literal", 64'(got_data[0]), 64'(40'h0505050505));
        check("t1 row4 literal", 64'(got_data[4]), 64'(40'h0505050505));
        check("t1 ovf_row", 64'(got_row), 64'(0));
        idle_check(2, '0);

        // Sub, mixed signs
        set_all(pack5(50, -40, 30, -20, 10), pack5(-45, 35, -25, 15, -5));
        run_cmd(1'b0, 1'b0);
        check("t2 row3 literal", 64'(got_data[3]), 64'(40'h5FB537DD0F));
        idle_check(1, '0);

        // Sub with overflow on row 2 only; flags must hold after done
        set_all('0, '0);
        mem_a[2] = pack5(50, -128, 127, -100, 100);
        mem_b[2] = pack5(-100, -1, 1, 30, 30);
        run_cmd(1'b0, 1'b0);
`ifdef MAT_SATURATE_EN
        check("t3 row2 literal", 64'(got_data[2]), 64'(40'h7F817E8046));
`else
        check("t3 row2 literal", 64'(got_data[2]), 64'(40'h96817E7E46));
`endif
        check("t3 ovf_row", 64'(got_row), 64'(5'b00100));
        idle_check(3, 5'b00100);

        // Add with overflow, then a back-to-back clean command accepted at E8
        set_all(pack5(127, 1, -128, 0, -1), pack5(1, 1, -1, 0, -1));
        run_cmd(1'b1, 1'b0);
`ifdef MAT_SATURATE_EN
        check("t4 row1 literal", 64'(got_data[1]), 64'(40'h7F028000FE));
`else
        check("t4 row1 literal", 64'(got_data[1]), 64'(40'h80027F00FE));
`endif
        check("t4 ovf_row", 64'(got_row), 64'(5'b11111));
        set_all(pack5(50, 40, 30, 20, 10), pack5(45, 35, 25, 15, 5));
        run_cmd(1'b0, 1'b0);
        check("b2b ovf_row cleared", 64'(got_row), 64'(0));
        idle_check(1, '0);

        // Start while busy with op flipped
        set_random();
        run_cmd(1'b1, 1'b1);
        idle_check(2, got_row);
        set_random();
        run_cmd(1'b0, 1'b1);
        idle_check(1, got_row);

        // Random commands, random op/inject, some back-to-back
        for (int i = 0; i < 14; i++) begin
            set_random();
            opv = 1'($urandom);
            inj = 1'($urandom);
            run_cmd(opv, inj);
            if ($urandom_range(0, 1) == 0) idle_check(int'($urandom_range(1, 3)), got_row);
        end
        idle_check(1, got_row);

        // Reset mid-command, after E4 (row 2 overflow already flagged)
        set_all('0, '0);
        mem_a[2] = pack5(50, -128, 127, -100, 100);
        mem_b[2] = pack5(-100, -1, 1, 30, 30);
        start = 1'b1;
        op    = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid ovf before reset", 64'(ovf), 64'(1));
        check("mid wr_en before reset", 64'(wr_en), 64'(1));
        rst = 1'b0;
        #1;
        check_all_zero("mid reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_check(6, '0);
        set_all(pack5(50, 40, 30, 20, 10), pack5(45, 35, 25, 15, 5));
        run_cmd(1'b0, 1'b0);
        check("post reset ovf_row", 64'(got_row), 64'(0));
        idle_check(2, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mat_addsub_ctrl.md
# mat_addsub_ctrl

Sequencer for the matrix coprocessor's element-wise add/subtract path. On a start command it streams five 40-bit rows of operand matrices A and B from the matrix bank and applies a lane-wise signed 8-bit add or subtract to each row pair. It writes each result row back to the bank and reports per-row and global overflow. It sits between the instruction decoder (start/op/done) and the matrix register bank (read/write row ports).

## Interface

**Parameters**

- `ROWS`, 5: rows per matrix.
- `LANES`, 5: elements per row.
- `LANE_W`, 8: element width, signed two's complement.

**Ports** (`W = LANES*LANE_W = 40`)

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = A−B, 1 = A+B; latched when `start` is accepted.
- `busy`  out  1  high from accepted start until `done`.
- `rd_en`  out  1  row read request to bank.
- `rd_addr`  out  3  row index 0..ROWS−1.
- `rd_data_a`  in  W  A row; valid the cycle after `rd_en`.
- `rd_data_b`  in  W  B row; valid the cycle after `rd_en`.
- `wr_en`  out  1  result row write strobe.
- `wr_addr`  out  3  result row index.
- `wr_data`  out  W  result row.
- `ovf`  out  1  sticky OR of all lane overflows of the current/last command.
- `ovf_row`  out  ROWS  bit r set if any lane of row r overflowed.
- `done`  out  1  one-cycle completion pulse.

## Operation

- Lane k occupies bits `[k*8+7:k*8]`. Lane 4 is MSB.
- Lane op: 9-bit signed add/sub of the sign-extended operands.
- Overflow when the result is outside −128..127. Default result is the low 8 bits (wrap).
- FSM states:
  - IDLE: `start` → RUN. Latch `op`, clear `ovf`/`ovf_row`, set `busy`.
  - RUN: `rd_en=1`, `rd_addr` = 0,1,2,3,4 on consecutive cycles. After addr 4 → DRAIN.
  - DRAIN: wait for the last two pipeline stages → DONE.
  - DONE: `done=1` for one cycle, `busy=0` next → IDLE.
- Pipeline stage 2 samples `rd_data_*` one cycle after each read. It registers `wr_data`, `wr_addr` and `wr_en`, and ORs lane overflows into `ovf_row[r]` and `ovf`.
- `start` while busy is ignored; no queuing.
- `op` changes after acceptance have no effect.
- `ovf`/`ovf_row` hold after `done` until the next accepted start.
- Reset (any state, including mid-command):
  - All outputs go to 0 immediately, state IDLE.
  - No partial write completes after reset release.

## Timing

- Accepting edge E0 (IDLE, `start=1`).
- `rd_en`/`rd_addr=r` are driven in the cycle after E(r), r = 0..4. `rd_en` is low after E5.
- Row r result: `wr_en=1`, `wr_addr=r` in the cycle after E(r+2), i.e. the cycles after E2..E6. Exactly 5 write cycles, back-to-back.
- `ovf_row[r]` updates at the same edge as row r's write.
- `done=1` in the cycle after E7. `busy` is high after E0..E6 and low after E7.
- Start-to-done latency is 7 cycles, and a new `start` is accepted at E8 at the earliest.
- Reset values: `busy`, `rd_en`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`, `ovf`, `ovf_row` and `done` are all 0.

## Configuration

- `MAT_SATURATE_EN` defined: overflowing lanes clamp to +127 (positive overflow) or −128 (negative overflow). `ovf`/`ovf_row` still flag the event.
- `MAT_SATURATE_EN` undefined: overflowing lanes wrap to the low 8 bits.
- Latency and handshake are identical in both builds.

## Test plan

- **Sub, no overflow.** Every row A = {50,40,30,20,10} (lane4..0), B = {45,35,25,15,5}, `op=0` → each `wr_data`=`0x0505050505`, `ovf=0`, `ovf_row=0`, `done` in the cycle after E7.
- **Sub, mixed signs.** A = {50,−40,30,−20,10}, B = {−45,35,−25,15,−5} → `wr_data`=`0x5FB537DD0F` ({95,−75,55,−35,15}), `ovf=0`.
- **Sub with overflow, only row 2.** Row 2 A = {50,−128,127,−100,100}, B = {−100,−1,1,30,30}, other rows zero.
  - Wrap build: row 2 = {0x96,0x81,0x7E,0x7E,0x46}, `ovf=1`, `ovf_row=5'b00100`.
  - `MAT_SATURATE_EN` build: {0x7F,0x81,0x7E,0x80,0x46}.
- **Add.** `op=1`, A = {127,1,−128,0,−1}, B = {1,1,−1,0,−1} → {0x80,0x02,0x7F,0x00,0xFE} wrap, `ovf=1`. Saturate build: {0x7F,0x02,0x80,0x00,0xFE}.
- **Start while busy.** Pulse `start` at E3 with `op` flipped → ignored: exactly 5 writes, original `op` used, single `done`.
- **Reset mid-command.** Assert `rst=0` after E4 → all outputs 0 asynchronously, no further `wr_en`. A new start after release runs a full clean 7-cycle command with cleared `ovf`.
